imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_DEPTH, default 256, SHALL give the instruction memory depth in 32-bit words; ADDR_W = clog2(IMEM_DEPTH).
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-004 start  in  1  SHALL be a one-cycle pulse that begins a load.
REQ-005 rx_data  in  8  SHALL carry the byte-stream payload.
REQ-006 rx_valid  in  1  SHALL mark rx_data as valid.
REQ-007 rx_ready  out  1  SHALL mark that the loader accepts a byte; a byte transfers on a cycle where rx_valid and rx_ready are both 1.
REQ-008 imem_we  out  1  SHALL be the instruction-memory write strobe.
REQ-009 imem_addr  out  ADDR_W  SHALL be the word address of the write.
REQ-010 imem_wdata  out  32  SHALL be the word to write.
REQ-011 core_hold  out  1  SHALL hold the core in reset while 1.
REQ-012 busy / done / error  out  1 each  SHALL report status.
REQ-013 words_loaded  out  ADDR_W+1  SHALL report the count of words written.

Function
REQ-014 The stream format SHALL be: a 4-byte length N in words, then N payload words, then a 4-byte checksum; every word SHALL be little-endian, with the first byte in [7:0].
REQ-015 The FSM SHALL have the states IDLE, LEN, LOAD, CSUM, DONE, ERROR.
REQ-016 IDLE->LEN SHALL occur on start; start SHALL also be accepted in DONE and ERROR; start SHALL be ignored in LEN, LOAD and CSUM.
REQ-017 rx_ready SHALL be 1 exactly in LEN, LOAD and CSUM; it SHALL be 0 in every other state, including the cycle imem_we is high.
REQ-018 A 2-bit byte counter SHALL increment on each transfer and wrap 3->0; the wrap SHALL complete a word.
REQ-019 In LEN, a completed word SHALL set N.
- N == 0 or N > IMEM_DEPTH SHALL go to ERROR.
- Otherwise the next state SHALL be LOAD.
REQ-020 In LOAD, a completed word SHALL pulse imem_we for exactly one cycle, on the cycle after the 4th-byte transfer, with imem_addr = words_loaded and imem_wdata = the assembled word.
- words_loaded SHALL increment in that same cycle.
- The running checksum SHALL be XORed with the word.
REQ-021 When words_loaded reaches N, the FSM SHALL go to CSUM.
REQ-022 In CSUM, a completed word equal to the running XOR SHALL go to DONE; a mismatch SHALL go to ERROR.
REQ-023 busy SHALL be 1 in LEN, LOAD and CSUM; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-024 core_hold SHALL be 0 only in DONE.
REQ-025 A start in DONE or ERROR SHALL clear words_loaded, the checksum, the byte counter and error, and SHALL enter LEN on the next cycle.
REQ-026 rx_valid with rx_ready = 0 SHALL have no effect; gaps in rx_valid SHALL stall without losing partial bytes.
REQ-027 The last write SHALL go to address N-1; imem_addr SHALL never reach IMEM_DEPTH.

Reset
REQ-028 rst SHALL force state IDLE and clear the byte counter, N, checksum and words_loaded.
- imem_we, rx_ready, busy, done and error SHALL be 0.
- imem_addr and imem_wdata SHALL be 0.
- core_hold SHALL be 1.
REQ-029 rst asserted mid-load SHALL abort within the same edge; words already written SHALL remain in memory, and no further write SHALL issue.

Structure
REQ-030 The loader_state_e enum and IMEM_DEPTH default SHALL live in riscv_pkg; XLEN SHALL be taken from riscv_pkg.
REQ-031 A single sub-module, byte_packer, SHALL implement the byte counter and little-endian word assembly; all remaining logic SHALL be in imem_loader.

Verification
REQ-032 Happy path: start, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | 80 00 10 00 -> writes (0, 0x00000013) and (1, 0x00100093), then done = 1, core_hold = 0, words_loaded = 2.
REQ-033 Zero length: length bytes 00 00 00 00 -> error = 1, rx_ready = 0, no imem_we.
REQ-034 Length over depth: N = 257 with IMEM_DEPTH = 256 -> ERROR, no writes.
REQ-035 Bad checksum: N = 1, word 0xDEADBEEF, checksum 0xDEADBEEE -> one write, then error = 1, core_hold = 1.
REQ-036 Stall and restart: rx_valid toggled randomly during LOAD gives identical writes; rst asserted after 3 payload bytes -> IDLE next cycle, core_hold = 1; a subsequent start and full stream -> done.
REQ-037 Ignored start: a start pulse during LOAD -> no state change and write sequence unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: data width, default
// memory depth and the loader state encoding.
package riscv_pkg;

    localparam int XLEN               = 32;
    localparam int IMEM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        LOAD,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

    // A load length is usable when it is non-zero and fits in the memory.
    function automatic logic length_ok(input logic [XLEN-1:0] n, input int depth);
        return (n != '0) && (n <= XLEN'(depth));
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Counts accepted bytes and assembles them little-endian into XLEN-bit words;
// word_done/word_data are valid combinationally on the transfer of the last byte.
module byte_packer
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            xfer,
    input  logic [7:0]      byte_in,
    output logic            word_done,
    output logic [XLEN-1:0] word_data
);

    localparam int LANES = XLEN / 8;

    logic [1:0] byte_cnt_reg;
    logic [7:0] lane_reg [LANES-1];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            byte_cnt_reg <= '0;
        end else if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    // Only the lower lanes are stored; the top byte is taken live from the
    // bus so the completed word is available on the final transfer itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES - 1; i++) begin
                lane_reg[i] <= '0;
            end
        end else if (xfer) begin
            for (int i = 0; i < LANES - 1; i++) begin
                if (byte_cnt_reg == 2'(i)) begin
                    lane_reg[i] <= byte_in;
                end
            end
        end
    end

    assign word_done = xfer && (byte_cnt_reg == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < LANES - 1; gi++) begin : g_lane
            assign word_data[8*gi +: 8] = lane_reg[gi];
        end
    endgenerate

    assign word_data[XLEN-1 -: 8] = byte_in;

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed byte stream and writes it into
// instruction memory, holding the core in reset until a load completes cleanly.
module imem_loader
    import riscv_pkg::*;
#(
    parameter  int IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [XLEN-1:0]   imem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [ADDR_W:0] WL_ONE = 1;

    loader_state_e     state_reg;
    logic [ADDR_W:0]   n_reg;
    logic [XLEN-1:0]   csum_reg;
    logic [ADDR_W:0]   words_loaded_reg;
    logic              imem_we_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [XLEN-1:0]   imem_wdata_reg;
    logic              rx_ready_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;
    logic              core_hold_reg;

    logic              xfer;
    logic              start_ok;
    logic              word_done;
    logic [XLEN-1:0]   word_data;
    logic [ADDR_W:0]   wl_inc;

    assign xfer     = rx_valid && rx_ready_reg;
    assign start_ok = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
    assign wl_inc   = words_loaded_reg + WL_ONE;

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .xfer      (xfer),
        .byte_in   (rx_data),
        .word_done (word_done),
        .word_data (word_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            n_reg            <= '0;
            csum_reg         <= '0;
            words_loaded_reg <= '0;
            imem_we_reg      <= 1'b0;
            imem_addr_reg    <= '0;
            imem_wdata_reg   <= '0;
            rx_ready_reg     <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            core_hold_reg    <= 1'b1;
        end else begin
            imem_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_reg        <= LEN;
                        n_reg            <= '0;
                        csum_reg         <= '0;
                        words_loaded_reg <= '0;
                        rx_ready_reg     <= 1'b1;
                        busy_reg         <= 1'b1;
                        done_reg         <= 1'b0;
                        error_reg        <= 1'b0;
                        core_hold_reg    <= 1'b1;
                    end
                end
                LEN: begin
                    if (word_done) begin
                        n_reg <= word_data[ADDR_W:0];
                        if (length_ok(word_data, IMEM_DEPTH)) begin
                            state_reg <= LOAD;
                        end else begin
                            state_reg    <= ERROR;
                            rx_ready_reg <= 1'b0;
                            busy_reg     <= 1'b0;
                            error_reg    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // Drop ready for the write cycle, then reopen the stream.
                    rx_ready_reg <= !word_done;
                    if (word_done) begin
                        imem_we_reg      <= 1'b1;
                        imem_addr_reg    <= words_loaded_reg[ADDR_W-1:0];
                        imem_wdata_reg   <= word_data;
                        words_loaded_reg <= wl_inc;
                        csum_reg         <= csum_reg ^ word_data;
                        if (wl_inc == n_reg) begin
                            state_reg <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (word_done) begin
                        rx_ready_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        if (word_data == csum_reg) begin
                            state_reg     <= DONE;
                            done_reg      <= 1'b1;
                            core_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ERROR;
                            error_reg <= 1'b1;
                        end
                    end else begin
                        rx_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx_ready     = rx_ready_reg;
    assign imem_we      = imem_we_reg;
    assign imem_addr    = imem_addr_reg;
    assign imem_wdata   = imem_wdata_reg;
    assign core_hold    = core_hold_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign error        = error_reg;
    assign words_loaded = words_loaded_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized byte streams against a stream-level model of the
// loader; memory writes are collected and compared with the expected words.
module tb_imem_loader;

    localparam int DEPTH = 256;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    byte_q_t     stim;
    logic [39:0] wr_q[$];
    logic [39:0] exp_wr[$];
    logic [31:0] mem_model [DEPTH];
    logic        exp_done;
    logic        exp_err;
    logic [8:0]  exp_wl;

    imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: records every memory write and the ready level alongside it.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_q.push_back({imem_addr, imem_wdata});
            mem_model[imem_addr] = imem_wdata;
            check("ready_low_on_we", 64'(rx_ready), 64'(0));
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
    endtask

    function automatic logic [31:0] word_at(input int p);
        return {stim[p+3], stim[p+2], stim[p+1], stim[p]};
    endfunction

    // Stream-level model: length word, payload words, XOR checksum word.
    task automatic model_run();
        logic [31:0] n;
        logic [31:0] w;
        logic [31:0] x;
        exp_wr.delete();
        x = '0;
        n = word_at(0);
        if (n == 0 || n > DEPTH) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            exp_wl   = '0;
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w = word_at(4 + 4*i);
            x ^= w;
            exp_wr.push_back({i[7:0], w});
        end
        exp_done = (word_at(4 + 4*int'(n)) == x);
        exp_err  = !exp_done;
        exp_wl   = n[8:0];
    endtask

    // Callers sit 1 time unit after a rising edge on entry and on exit.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        int g;
        if (gaps) begin
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("rx_ready_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_stream(input string name, input bit gaps, input int glitch_at);
        int nw;
        wr_q.delete();
        model_run();
        pulse_start();
        for (int i = 0; i < stim.size(); i++) begin
            send_byte(stim[i], gaps);
            if (i == glitch_at) pulse_start();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({name, "_wr_count"}, 64'(wr_q.size()), 64'(exp_wr.size()));
        nw = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < nw; i++)
            check($sformatf("%s_wr%0d", name, i), 64'(wr_q[i]), 64'(exp_wr[i]));
        check({name, "_done"},      64'(done),         64'(exp_done));
        check({name, "_error"},     64'(error),        64'(exp_err));
        check({name, "_core_hold"}, 64'(core_hold),    64'(!exp_done));
        check({name, "_busy"},      64'(busy),         64'(0));
        check({name, "_rx_ready"},  64'(rx_ready),     64'(0));
        check({name, "_words"},     64'(words_loaded), 64'(exp_wl));
        $display("stream %s: %0d bytes, %0d writes, done=%0d error=%0d",
                 name, stim.size(), wr_q.size(), done, error);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] w;
        int n;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_rx_ready",  64'(rx_ready),     64'(0));
        check("rst_we",        64'(imem_we),      64'(0));
        check("rst_addr",      64'(imem_addr),    64'(0));
        check("rst_wdata",     64'(imem_wdata),   64'(0));
        check("rst_busy",      64'(busy),         64'(0));
        check("rst_done",      64'(done),         64'(0));
        check("rst_error",     64'(error),        64'(0));
        check("rst_core_hold", 64'(core_hold),    64'(1));
        check("rst_words",     64'(words_loaded), 64'(0));
        $display("reset: core_hold=%0d busy=%0d", core_hold, busy);
        @(posedge clk); #1;

        // Reference program of two instructions
        stim.delete();
        push_word(32'd2); push_word(32'h0000_0013); push_word(32'h0010_0093); push_word(32'h0010_0080);
        run_stream("happy", 1'b0, -1);
        check("happy_w0", 64'(mem_model[0]), 64'(32'h0000_0013));
        check("happy_w1", 64'(mem_model[1]), 64'(32'h0010_0093));

        run_stream("happy_gaps", 1'b1, -1);
        run_stream("ignored_start", 1'b0, 6);

        stim.delete();
        push_word(32'd0);
        run_stream("zero_len", 1'b0, -1);

        stim.delete();
        push_word(32'd257);
        run_stream("over_depth", 1'b0, -1);

        stim.delete();
        push_word(32'd1); push_word(32'hDEAD_BEEF); push_word(32'hDEAD_BEEE);
        run_stream("bad_csum", 1'b0, -1);

        // Maximum length fills the whole memory
        stim.delete();
        push_word(32'(DEPTH));
        x = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom; x ^= w; push_word(w);
        end
        push_word(x);
        run_stream("full_depth", 1'b0, -1);

        for (int t = 0; t < 6; t++) begin
            stim.delete();
            n = $urandom_range(1, 8);
            push_word(32'(n));
            x = '0;
            for (int i = 0; i < n; i++) begin
                w = $urandom; x ^= w; push_word(w);
            end
            if ($urandom_range(0, 3) == 0) x ^= (32'd1 << $urandom_range(0, 31));
            push_word(x);
            run_stream($sformatf("rand%0d", t), 1'b1, -1);
        end

        // Reset in the middle of the second payload word
        stim.delete();
        push_word(32'd2); push_word(32'hCAFE_0001); push_word(32'h1234_5678);
        push_word(32'hCAFE_0001 ^ 32'h1234_5678);
        wr_q.delete();
        mem_model[0] = '0;
        pulse_start();
        for (int i = 0; i < 11; i++) send_byte(stim[i], 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",      64'(busy),         64'(0));
        check("abort_core_hold", 64'(core_hold),    64'(1));
        check("abort_rx_ready",  64'(rx_ready),     64'(0));
        check("abort_words",     64'(words_loaded), 64'(0));
        repeat (5) @(negedge clk);
        check("abort_wr_count",  64'(wr_q.size()),  64'(1));
        check("abort_mem0",      64'(mem_model[0]), 64'(32'hCAFE_0001));
        $display("abort: %0d writes kept, core_hold=%0d", wr_q.size(), core_hold);
        @(posedge clk); #1;
        run_stream("after_abort", 1'b0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
